bcd_to_binary_seq: RTL and testbench
====================================

# bcd_to_binary_seq

Sequential converter from packed BCD to unsigned binary; the inverse of the team's binary-to-BCD path. It accepts a DIGITS-digit BCD word over a valid/ready handshake, folds one digit per clock (MSD first) into an accumulator as acc·10 + digit, and presents the binary result on a second valid/ready handshake. It sits between BCD-producing front ends (keypad/display registers) and binary datapaths.

## Interface
- DIGITS, 5: number of BCD digits in the input word.
- BIN_W, 17: output width. Must be at least ceil(log2(10^DIGITS)); 17 covers 99999.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  converter idle and able to accept; equals (state == IDLE).
- bcd_in  in  4·DIGITS  packed BCD; bits [4·DIGITS-1 -: 4] are the most significant digit.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- binary  out  BIN_W  converted value.
- err  out  1  at least one input digit was greater than 9; qualified by out_valid.

## Operation
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready: latch bcd_in into the shift register, acc ← 0, cnt ← 0, go to CONV.
  - CONV: each edge does acc ← (acc·10 + top digit) mod 2^BIN_W, shifts the register left by 4, and cnt ← cnt + 1. After the DIGITS-th CONV edge (cnt == DIGITS-1), go to HOLD.
  - HOLD: out_valid = 1. On out_valid & out_ready, go to IDLE.
- in_valid is ignored outside IDLE. bcd_in is sampled only at the accepting edge and may change afterwards.
- Arithmetic: acc·10 is computed as (acc<<3) + (acc<<1), truncated to BIN_W. Out-of-range digits (10–15) are used at their raw value, so the result wraps modulo 2^BIN_W.
- err: cleared at acceptance and sticky across CONV. It is set when any digit is greater than 9, and only if the macro described under Configuration is defined.
- binary and err are held stable for the whole of HOLD, regardless of out_ready.
- Reset values: state IDLE, in_ready 1, out_valid 0, binary 0, err 0, acc 0, cnt 0.
- Reset mid-operation: any conversion in progress is discarded immediately (asynchronous). After rst_n deasserts the block is in IDLE; no stale out_valid is produced.

## Timing
- Accepting edge E0. The DIGITS CONV edges are E1..E_DIGITS. out_valid is high after edge E_DIGITS, giving a latency of DIGITS cycles from acceptance.
- Taking the result (out_valid & out_ready) at edge Ek returns the block to IDLE, with in_ready high after Ek.
- There is no accept-in-HOLD bypass. Best-case throughput is one word per DIGITS + 2 cycles.
- out_ready may be held high permanently. HOLD still lasts exactly one cycle in that case.
- All outputs are registered or decoded from state only. There is no combinational path from input to output.

## Configuration
- BCD2BIN_CHECK_EN:
  - Defined: a per-digit >9 comparator feeds the sticky err flag.
  - Undefined: the comparator is not built and err is tied to 0.
- The binary result and the handshake are identical in both builds.

## Structure
- Package bcd_pkg holds:
  - DIGIT_W = 4.
  - The state typedef (IDLE, CONV, HOLD).
  - Function bin_width(digits) that returns the minimum BIN_W, used for an elaboration-time check BIN_W ≥ bin_width(DIGITS).
- Sub-module bcd_digit_mac is combinational: it takes acc, digit and produces acc·10 + digit truncated to BIN_W, plus a digit_bad flag. digit_bad is used only under BCD2BIN_CHECK_EN.

## Test plan
- Conversion of 99999: bcd_in = 0x99999 with out_ready held 1 → out_valid exactly 5 cycles after acceptance, binary = 0x1869F (99999), err = 0.
- Two back-to-back words: 0x12345 then 0x00000 → binary 0x3039 then 0x00000. in_ready is low for the whole of CONV and HOLD of the first word.
- Invalid digit, bcd_in = 0x1A000:
  - With BCD2BIN_CHECK_EN: err = 1, binary = 20000 (0x4E20).
  - Without BCD2BIN_CHECK_EN: err = 0, same binary.
- Back-pressure: out_ready held 0 for 10 cycles in HOLD while in_valid toggles with new data → binary, err and out_valid stable, no new acceptance. Raising out_ready gives a single transfer, then in_ready = 1.
- Mid-conversion reset: rst_n pulsed low at E2 of 0x54321 → out_valid 0 and binary 0 immediately. After release, in_ready = 1 and the next word 0x00042 converts to 42.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential BCD-to-binary converter.
//   DIGIT_W   : width of one packed BCD digit
//   state_t   : converter FSM states (IDLE, CONV, HOLD)
//   bin_width : minimum binary width able to hold the largest value
//               representable with a given number of decimal digits
// ---------------------------------------------------------------------------
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Smallest w with 2^w >= 10^digits, i.e. ceil(log2(10^digits)).
  // Used at elaboration time to reject an undersized output width.
  function automatic int bin_width(input int digits);
    longint unsigned pow10;
    int w;
    pow10 = 64'd1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 64'd10;
    end
    w = 0;
    for (int b = 0; b < 64; b++) begin
      if ((64'd1 << b) < pow10) begin
        w = b + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// ---------------------------------------------------------------------------
// bcd_digit_mac
// Combinational multiply-accumulate step of the BCD-to-binary conversion:
// next_acc = acc*10 + digit, truncated to BIN_W bits.
//   acc       in  BIN_W    running binary accumulator
//   digit     in  DIGIT_W  current BCD digit (raw value, 0..15)
//   next_acc  out BIN_W    acc*10 + digit modulo 2^BIN_W
//   digit_bad out 1        digit is greater than 9
// Optional feature macro: BCD2BIN_CHECK_EN builds the >9 comparator;
// without it digit_bad is tied to 0.
// ---------------------------------------------------------------------------
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 17
) (
  input  logic [BIN_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]   next_acc,
  output logic               digit_bad
);

  // Multiply by ten as 8x + 2x so no multiplier is inferred; every term is
  // BIN_W wide so the sum wraps naturally.
  assign next_acc = (acc << 3) + (acc << 1) + BIN_W'(digit);

`ifdef BCD2BIN_CHECK_EN
  assign digit_bad = (digit > 4'd9);
`else
  assign digit_bad = 1'b0;
`endif

endmodule

// File: rtl/bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential packed-BCD to unsigned binary converter. Accepts one DIGITS-digit
// word over a valid/ready handshake, folds one digit per clock (most
// significant first) as acc*10 + digit, and offers the result on a second
// valid/ready handshake.
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          input word present
//   in_ready   out  1          idle and able to accept (state == IDLE)
//   bcd_in     in   4*DIGITS   packed BCD, MSD in the top nibble
//   out_valid  out  1          result present (state == HOLD)
//   out_ready  in   1          consumer takes the result
//   binary     out  BIN_W      converted value
//   err        out  1          some input digit was > 9 (qualified by out_valid)
// Optional feature macro: BCD2BIN_CHECK_EN enables the sticky err flag;
// without it err is tied to 0. The binary path is identical in both builds.
// ---------------------------------------------------------------------------
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIN_W-1:0]            binary,
  output logic                        err
);

  localparam int WORD_W = DIGIT_W * DIGITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Refuse to elaborate if the output cannot hold the largest decimal value.
  if (BIN_W < bin_width(DIGITS)) begin : g_width_check
    $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
  end

  state_t             state;
  logic [WORD_W-1:0]  sreg;
  logic [BIN_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   mac_acc;

`ifdef BCD2BIN_CHECK_EN
  logic digit_bad;
  logic err_r;
`else
  logic digit_bad_unused;
`endif

  // The digit currently being folded is always the top nibble of the shift
  // register; the register shifts left once per CONV cycle.
  bcd_digit_mac #(
    .BIN_W (BIN_W)
  ) u_mac (
    .acc       (acc),
    .digit     (sreg[WORD_W-1 -: DIGIT_W]),
    .next_acc  (mac_acc),
`ifdef BCD2BIN_CHECK_EN
    .digit_bad (digit_bad)
`else
    .digit_bad (digit_bad_unused)
`endif
  );

  // Converter FSM. IDLE latches the word and clears the accumulator, CONV
  // folds exactly DIGITS digits, HOLD presents the result until taken. The
  // accumulator doubles as the output register, so binary stays frozen
  // throughout HOLD and drops to zero immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
`ifdef BCD2BIN_CHECK_EN
      err_r <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= bcd_in;
            acc   <= '0;
            cnt   <= '0;
`ifdef BCD2BIN_CHECK_EN
            err_r <= 1'b0;
`endif
            state <= CONV;
          end
        end
        CONV: begin
          acc  <= mac_acc;
          sreg <= sreg << DIGIT_W;
          cnt  <= cnt + CNT_W'(1);
`ifdef BCD2BIN_CHECK_EN
          err_r <= err_r | digit_bad;
`endif
          if (cnt == CNT_W'(DIGITS - 1)) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign binary    = acc;

`ifdef BCD2BIN_CHECK_EN
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_binary_seq
// Self-checking bench for bcd_to_binary_seq (DIGITS=5, BIN_W=17). A
// transaction-level model predicts handshake timing and the converted value
// from decimal place weights; a per-cycle compare process checks the DUT
// against it, and directed tests add hand-computed literal expectations.
// Honours BCD2BIN_CHECK_EN for the expected err value.
// ---------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 5;
  localparam int BIN_W  = 17;
  localparam int WORD_W = 20;

`ifdef BCD2BIN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] bcd_in = '0;
  logic              in_ready;
  logic              out_valid;
  logic [BIN_W-1:0]  binary;
  logic              err;

  int total = 0;
  int bad   = 0;

  // Model state: busy counting down the conversion, or holding a result.
  bit               m_busy = 1'b0;
  bit               m_valid = 1'b0;
  int               m_left = 0;
  logic [BIN_W-1:0] m_bin = '0;
  bit               m_err = 1'b0;

  bcd_to_binary_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .binary    (binary),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Value of a packed BCD word as a sum of digit * 10^position, with raw
  // digit values, reduced modulo 2^BIN_W.
  function automatic logic [BIN_W-1:0] model_value(input logic [WORD_W-1:0] w);
    longint unsigned sum;
    longint unsigned weight;
    sum = 0;
    weight = 1;
    for (int i = 0; i < DIGITS; i++) begin
      sum = sum + 64'(w[4*i +: 4]) * weight;
      weight = weight * 10;
    end
    return sum[BIN_W-1:0];
  endfunction

  function automatic bit model_bad(input logic [WORD_W-1:0] w);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: a word accepted while idle yields its result DIGITS
  // edges later; the result is held until an edge sees out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_left  = 0;
      m_bin   = '0;
      m_err   = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
      end
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_left = DIGITS;
      m_bin  = model_value(bcd_in);
      m_err  = CHECK_EN && model_bad(bcd_in);
    end
  end

  // Per-cycle comparison against the model, sampled just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        checkOutput("cyc_in_ready", 32'(in_ready), 32'(!m_busy && !m_valid));
        checkOutput("cyc_out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
          checkOutput("cyc_binary", 32'(binary), 32'(m_bin));
          checkOutput("cyc_err", 32'(err), 32'(m_err));
        end
      end
    end
  end

  // Present a word and wait for it to be accepted; returns at the falling
  // edge after the accepting edge with in_valid dropped and bcd_in scrambled.
  task automatic applyStimulus(input logic [WORD_W-1:0] word);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    bcd_in   = word;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for word 0x%0h", word);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = 20'hFEDCB;
  endtask

  // Count edges from acceptance until out_valid is seen, bounded.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL result_timeout: out_valid 0 after %0d cycles, required 1", lat);
    end
  endtask

  initial begin
    int lat;
    $display("[TB] starting bcd_to_binary_seq bench, CHECK_EN=%0d", CHECK_EN);

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_binary", 32'(binary), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Full-scale word with the consumer always ready.
    out_ready = 1'b1;
    applyStimulus(20'h99999);
    waitResult(lat);
    checkOutput("lat_99999", 32'(lat), 32'd5);
    checkOutput("bin_99999", 32'(binary), 32'h1869F);
    checkOutput("model_99999", 32'(m_bin), 32'h1869F);
    checkOutput("err_99999", 32'(err), 32'd0);
    @(negedge clk);
    checkOutput("hold_one_cycle", 32'(out_valid), 32'd0);
    checkOutput("idle_after_take", 32'(in_ready), 32'd1);

    // Back-to-back words.
    applyStimulus(20'h12345);
    checkOutput("b2b_busy", 32'(in_ready), 32'd0);
    waitResult(lat);
    checkOutput("bin_12345", 32'(binary), 32'h3039);
    applyStimulus(20'h00000);
    waitResult(lat);
    checkOutput("lat_00000", 32'(lat), 32'd5);
    checkOutput("bin_00000", 32'(binary), 32'h0);

    // Out-of-range digit: raw value 10 in the thousands place.
    applyStimulus(20'h1A000);
    waitResult(lat);
    checkOutput("bin_1A000", 32'(binary), 32'd20000);
    checkOutput("model_1A000", 32'(m_bin), 32'd20000);
    checkOutput("err_1A000", 32'(err), 32'(CHECK_EN));

    // Back-pressure in HOLD with in_valid toggling new data.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(20'h00777);
    waitResult(lat);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_binary", 32'(binary), 32'd777);
      checkOutput("bp_err", 32'(err), 32'd0);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = i[0];
      bcd_in   = 20'($urandom);
      @(negedge clk);
    end
    checkOutput("bp_end_binary", 32'(binary), 32'd777);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a conversion.
    applyStimulus(20'h54321);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_binary", 32'(binary), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("after_rst_out_valid", 32'(out_valid), 32'd0);
    applyStimulus(20'h00042);
    waitResult(lat);
    checkOutput("lat_42", 32'(lat), 32'd5);
    checkOutput("bin_42", 32'(binary), 32'd42);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
